// File: rtl/iram_loader_pkg.sv
// Shared constants and state encoding for the microcode RAM loader and RAM wrapper.
package iram_loader_pkg;
    localparam int IRAM_SIZE = 21504;
    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 32;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        VREAD,
        VDRAIN,
        VCHK,
        DONE
    } state_t;

    // Widened add so a range ending past the top of the RAM cannot wrap back in.
    function automatic logic range_ok(input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] cnt);
        logic [ADDR_W+1:0] end_addr;
        end_addr = {2'b00, base} + {2'b00, cnt};
        return end_addr <= (ADDR_W+2)'(IRAM_SIZE);
    endfunction
endpackage

// File: rtl/iram_loader_if.sv
// Byte stream and RAM write/read port between the loader (master) and its environment.
interface iram_loader_if;
    import iram_loader_pkg::*;

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic              mem_rden;
    logic [DATA_W-1:0] mem_q;

    modport master (
        input  in_data, in_valid, mem_q,
        output in_ready, mem_addr, mem_data, mem_wren, mem_rden
    );

    modport slave (
        output in_data, in_valid, mem_q,
        input  in_ready, mem_addr, mem_data, mem_wren, mem_rden
    );
endinterface

// File: rtl/iram_byte_packer.sv
// Packs accepted stream bytes little-endian into a 32-bit word; pulses word_valid after lane 3.
module iram_byte_packer
    import iram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_ready,
    output logic              last_byte,
    output logic [DATA_W-1:0] word_nxt,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);
    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              word_valid_q, word_valid_d;
    logic              take;

    always_comb begin
        take   = in_valid & in_ready;
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d  = '0;
            word_d = '0;
        end else if (take) begin
            case (idx_q)
                2'd0:    word_d[7:0]   = in_data;
                2'd1:    word_d[15:8]  = in_data;
                2'd2:    word_d[23:16] = in_data;
                default: word_d[31:24] = in_data;
            endcase
            idx_d = idx_q + 2'd1;
        end
        last_byte    = take & ~clear & (idx_q == 2'd3);
        word_valid_d = last_byte;
        word_nxt     = word_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
endmodule

// File: rtl/iram_loader.sv
// Microcode RAM write-side loader: stream -> words -> consecutive RAM writes, optional read-back checksum.
//   state  | meaning
//   IDLE   | waiting for start
//   FILL   | accepting bytes of the current word
//   WRITE  | one-cycle RAM write of the packed word
//   VREAD  | issuing word_count back-to-back reads from base
//   VDRAIN | collecting the last read data
//   VCHK   | comparing read-back sum against write checksum
//   DONE   | one-cycle completion pulse
module iram_loader
    import iram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              verify_en,
    iram_loader_if.master     bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, count_q, count_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, remaining_q, remaining_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d, checksum_q, checksum_d, vsum_q, vsum_d;
    logic              ven_q, ven_d, rd_vld_q, rd_vld_d;
    logic              in_ready_q, in_ready_d, mem_wren_q, mem_wren_d, mem_rden_q, mem_rden_d;
    logic              busy_q, busy_d, done_q, done_d, error_q, error_d;

    logic              pk_clear, pk_last, pk_word_valid;
    logic [DATA_W-1:0] pk_word_nxt, pk_word;

    iram_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pk_clear),
        .in_data    (bus.in_data),
        .in_valid   (bus.in_valid),
        .in_ready   (in_ready_q),
        .last_byte  (pk_last),
        .word_nxt   (pk_word_nxt),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        ven_d       = ven_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        checksum_d  = checksum_q;
        error_d     = error_q;
        pk_clear    = 1'b0;
        rd_vld_d    = mem_rden_q;
        vsum_d      = rd_vld_q ? (vsum_q + bus.mem_q) : vsum_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    count_d     = word_count;
                    ven_d       = verify_en;
                    cur_addr_d  = base_addr;
                    remaining_d = word_count;
                    error_d     = 1'b0;
                    checksum_d  = '0;
                    vsum_d      = '0;
                    pk_clear    = 1'b1;
                    if (word_count == '0) begin
                        state_d = DONE;
                    end else if (!range_ok(base_addr, word_count)) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (pk_last) begin
                    mem_addr_d = cur_addr_q;
                    mem_data_d = pk_word_nxt;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (pk_word_valid) begin
                    checksum_d  = checksum_q + pk_word;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                    if (remaining_q != ADDR_W'(1)) begin
                        state_d = FILL;
                    end else if (ven_q) begin
                        // Read-back restarts at base; the first read issues on VREAD entry.
                        mem_addr_d  = base_q;
                        cur_addr_d  = base_q + ADDR_W'(1);
                        remaining_d = count_q;
                        state_d     = VREAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            VREAD: begin
                if (remaining_q == ADDR_W'(1)) begin
                    remaining_d = '0;
                    state_d     = VDRAIN;
                end else begin
                    mem_addr_d  = cur_addr_q;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                end
            end
            VDRAIN: state_d = VCHK;
            VCHK: begin
                if (vsum_q != checksum_q) error_d = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == FILL);
        mem_wren_d = (state_d == WRITE);
        mem_rden_d = (state_d == VREAD);
        busy_d     = (state_d == FILL) || (state_d == WRITE) || (state_d == VREAD) ||
                     (state_d == VDRAIN) || (state_d == VCHK);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            ven_q       <= 1'b0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            checksum_q  <= '0;
            vsum_q      <= '0;
            rd_vld_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_rden_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            ven_q       <= ven_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            checksum_q  <= checksum_d;
            vsum_q      <= vsum_d;
            rd_vld_q    <= rd_vld_d;
            in_ready_q  <= in_ready_d;
            mem_wren_q  <= mem_wren_d;
            mem_rden_q  <= mem_rden_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.mem_wren = mem_wren_q;
    assign bus.mem_rden = mem_rden_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign checksum     = checksum_q;
endmodule

// File: tb/tb_iram_loader.sv
// Bench for iram_loader: table of directed loads, hand-written corner sequences, random loads vs a word-level model.
module tb_iram_loader;
    import iram_loader_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              verify_en = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] word_count = '0;
    logic              busy, done, error;
    logic [DATA_W-1:0] checksum;

    iram_loader_if bus();

    iram_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .verify_en  (verify_en),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // RAM model with 1-cycle read latency and an optional corrupted read-back location.
    logic [DATA_W-1:0] ram [0:IRAM_SIZE-1];
    logic [DATA_W-1:0] q_r = '0;
    logic              corrupt_en = 1'b0;
    logic [ADDR_W-1:0] corrupt_addr = '0;
    logic [DATA_W-1:0] corrupt_xor = '0;

    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
        if (bus.mem_rden)
            q_r <= ram[bus.mem_addr] ^ ((corrupt_en && bus.mem_addr == corrupt_addr) ? corrupt_xor : 32'h0);
    end
    assign bus.mem_q = q_r;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } acc_t;

    acc_t wr_q[$];
    acc_t rd_q[$];
    int   cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, both_cnt = 0;
    logic done_err = 0, done_busy = 0, start_busy = 0, start_err = 0, mark_start = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.mem_wren) wr_q.push_back('{bus.mem_addr, bus.mem_data, cyc});
        if (bus.mem_rden) rd_q.push_back('{bus.mem_addr, 32'h0, cyc});
        if (bus.mem_wren && bus.mem_rden) both_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_err  = error;
            done_busy = busy;
        end
        if (start && mark_start) begin
            start_cyc  = cyc;
            start_busy = busy;
            start_err  = error;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    logic [7:0] stim [0:31];

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", {31'b0, bus.in_ready}, 32'd1);
        else @(posedge clk);
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c,
                               input logic v, input logic mark);
        @(negedge clk);
        bus.in_valid = 1'b0;
        start        = 1'b1;
        base_addr    = b;
        word_count   = c;
        verify_en    = v;
        mark_start   = mark;
        @(negedge clk);
        start      = 1'b0;
        mark_start = 1'b0;
        base_addr  = ADDR_W'($urandom);
        word_count = ADDR_W'($urandom);
        verify_en  = 1'($urandom);
    endtask

    // Model works on whole words: expected writes, sum, read-back sum and error from the load rules.
    task automatic run_load(input string name, input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] cnt,
                            input logic ven, input int gap_max, input int inj_at);
        logic [31:0] words[$];
        logic [31:0] w, sum, rsum;
        logic [ADDR_W-1:0] a;
        logic bad, exp_err;
        int nw, exp_rd, n0, b0;
        bad = (cnt != 0) && ((int'(base) + int'(cnt)) > IRAM_SIZE);
        nw  = (bad || cnt == 0) ? 0 : int'(cnt);
        sum = 0;
        rsum = 0;
        for (int i = 0; i < nw; i++) begin
            w = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            words.push_back(w);
            sum += w;
            a = base + ADDR_W'(i);
            rsum += w ^ ((corrupt_en && a == corrupt_addr) ? corrupt_xor : 32'h0);
        end
        exp_err = bad || (ven && nw > 0 && rsum != sum);
        exp_rd  = (ven && nw > 0) ? nw : 0;

        wr_q.delete();
        rd_q.delete();
        n0 = done_cnt;
        b0 = both_cnt;
        pulse_start(base, cnt, ven, 1'b1);
        chk({name, " busy_after_start"}, {31'b0, start_busy}, {31'b0, nw > 0});
        chk({name, " error_at_start"}, {31'b0, start_err}, {31'b0, bad});

        if (nw == 0) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h5A;
            @(negedge clk);
            chk({name, " no_accept_idle"}, {31'b0, bus.in_ready}, 32'd0);
            bus.in_valid = 1'b0;
        end
        for (int k = 0; k < 4*nw; k++) begin
            send_byte(stim[k], $urandom_range(0, gap_max));
            if (k == inj_at) pulse_start(15'h5000, 15'h7fff, 1'b1, 1'b0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;

        for (int t = 0; t < 500 && done_cnt == n0; t++) @(negedge clk);
        repeat (3) @(negedge clk);

        chk({name, " done_pulses"}, 32'(done_cnt - n0), 32'd1);
        chk({name, " write_count"}, 32'(wr_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wr_q.size(); i++) begin
            chk($sformatf("%s wr%0d_addr", name, i), 32'(wr_q[i].addr), 32'(base + ADDR_W'(i)));
            chk($sformatf("%s wr%0d_data", name, i), wr_q[i].data, words[i]);
        end
        if (gap_max == 0 && nw > 1 && wr_q.size() > 1)
            chk({name, " word_period"}, 32'(wr_q[1].cyc - wr_q[0].cyc), 32'd5);
        chk({name, " read_count"}, 32'(rd_q.size()), 32'(exp_rd));
        for (int i = 0; i < exp_rd && i < rd_q.size(); i++) begin
            chk($sformatf("%s rd%0d_addr", name, i), 32'(rd_q[i].addr), 32'(base + ADDR_W'(i)));
            if (i > 0) chk($sformatf("%s rd%0d_consec", name, i), 32'(rd_q[i].cyc - rd_q[i-1].cyc), 32'd1);
        end
        chk({name, " checksum"}, checksum, sum);
        chk({name, " error_with_done"}, {31'b0, done_err}, {31'b0, exp_err});
        chk({name, " error_sticky"}, {31'b0, error}, {31'b0, exp_err});
        chk({name, " busy_at_done"}, {31'b0, done_busy}, 32'd0);
        chk({name, " busy_after"}, {31'b0, busy}, 32'd0);
        chk({name, " wren_rden_overlap"}, 32'(both_cnt - b0), 32'd0);
        if (nw == 0)
            chk({name, " done_latency"}, 32'(done_cyc - start_cyc), 32'd0);
        else if (exp_rd > 0 && rd_q.size() > 0)
            chk({name, " done_after_read"}, 32'(done_cyc - rd_q[rd_q.size()-1].cyc), 32'd3);
        else if (wr_q.size() > 0)
            chk({name, " done_after_write"}, 32'(done_cyc - wr_q[wr_q.size()-1].cyc), 32'd1);
    endtask

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] cnt;
        logic              ven;
        logic              corrupt;
        logic [31:0]       w0;
        logic [31:0]       w1;
        logic              exp_err;
        logic [31:0]       exp_cks;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [ADDR_W-1:0] rb, rc;
        vecs[0] = '{"plain",    15'h0010, 15'd2, 1'b0, 1'b0, 32'h04030201, 32'hDDCCBBAA, 1'b0, 32'hE1CFBDAB};
        vecs[1] = '{"verify",   15'h0010, 15'd2, 1'b1, 1'b0, 32'h04030201, 32'hDDCCBBAA, 1'b0, 32'hE1CFBDAB};
        vecs[2] = '{"corrupt",  15'h0010, 15'd2, 1'b1, 1'b1, 32'h04030201, 32'hDDCCBBAA, 1'b1, 32'hE1CFBDAB};
        vecs[3] = '{"last_adr", 15'h53FF, 15'd1, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0, 32'hCAFEF00D};
        vecs[4] = '{"overflow", 15'h53FF, 15'd2, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 1'b1, 32'h0};
        vecs[5] = '{"zero_cnt", 15'h0040, 15'd0, 1'b1, 1'b0, 32'h33333333, 32'h0,        1'b0, 32'h0};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst error", {31'b0, error}, 32'd0);
        chk("rst in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("rst wren", {31'b0, bus.mem_wren}, 32'd0);
        chk("rst rden", {31'b0, bus.mem_rden}, 32'd0);
        chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst mem_data", bus.mem_data, 32'd0);
        chk("rst checksum", checksum, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle in_ready", {31'b0, bus.in_ready}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < 4; b++) begin
                stim[b]   = vecs[i].w0[8*b +: 8];
                stim[b+4] = vecs[i].w1[8*b +: 8];
            end
            corrupt_en   = vecs[i].corrupt;
            corrupt_addr = 15'h0011;
            corrupt_xor  = 32'h1;
            run_load(vecs[i].name, vecs[i].base, vecs[i].cnt, vecs[i].ven, 0, -1);
            chk({vecs[i].name, " tbl_checksum"}, checksum, vecs[i].exp_cks);
            chk({vecs[i].name, " tbl_error"}, {31'b0, error}, {31'b0, vecs[i].exp_err});
            if (vecs[i].corrupt) begin
                repeat (5) @(negedge clk);
                chk({vecs[i].name, " error_held"}, {31'b0, error}, 32'd1);
            end
        end
        corrupt_en = 1'b0;

        for (int k = 0; k < 8; k++) stim[k] = 8'($urandom);
        run_load("ign_start", 15'h0100, 15'd2, 1'b0, 1, 1);

        for (int k = 0; k < 16; k++) stim[k] = 8'($urandom);
        w = {stim[3], stim[2], stim[1], stim[0]};
        wr_q.delete();
        pulse_start(15'h0200, 15'd4, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) send_byte(stim[k], $urandom_range(0, 3));
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset_n      = 1'b0;
        #1;
        chk("mid_rst busy", {31'b0, busy}, 32'd0);
        chk("mid_rst in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("mid_rst wren", {31'b0, bus.mem_wren}, 32'd0);
        chk("mid_rst mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("mid_rst mem_data", bus.mem_data, 32'd0);
        chk("mid_rst checksum", checksum, 32'd0);
        chk("mid_rst writes", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) chk("mid_rst wr_data", wr_q[0].data, w);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) stim[k] = 8'($urandom);
        run_load("after_rst", 15'h0300, 15'd2, 1'b1, 2, -1);

        for (int r = 0; r < 16; r++) begin
            if ($urandom_range(0, 4) == 0) rb = ADDR_W'(IRAM_SIZE - int'($urandom_range(0, 3)));
            else                           rb = ADDR_W'($urandom_range(0, IRAM_SIZE - 8));
            rc           = ADDR_W'($urandom_range(0, 5));
            corrupt_en   = ($urandom_range(0, 3) == 0);
            corrupt_addr = rb + ADDR_W'($urandom_range(0, 3));
            corrupt_xor  = $urandom | 32'h1;
            for (int k = 0; k < 20; k++) stim[k] = 8'($urandom);
            run_load($sformatf("rnd%0d", r), rb, rc, 1'($urandom), 3, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/iram_loader.md
Name: iram_loader

Overview:
- Write-side initiator for the 21504x32 dual-port microcode RAM.
- Accepts a byte stream from the host/boot path over valid/ready and packs 4 bytes, little-endian, into each 32-bit word.
- Writes the words to consecutive RAM addresses on one RAM port.
- Optionally reads the range back and compares a 32-bit additive checksum before signalling completion.

Parameters:
IRAM_SIZE, 21504, number of RAM words; highest legal address is IRAM_SIZE-1
ADDR_W, 15, RAM address width
DATA_W, 32, RAM word width (fixed at 4 bytes)

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a load; ignored while busy
base_addr  input  ADDR_W  first RAM address; sampled on start
word_count  input  ADDR_W  number of words to load; sampled on start
verify_en  input  1  enables read-back checksum pass; sampled on start
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle
mem_addr  output  ADDR_W  RAM address
mem_data  output  DATA_W  RAM write data
mem_wren  output  1  RAM write enable
mem_rden  output  1  RAM read enable
mem_q  input  DATA_W  RAM read data; valid 1 cycle after mem_rden
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle completion pulse
error  output  1  sticky; cleared on next accepted start
checksum  output  DATA_W  mod-2^32 sum of words written by the last load

Behaviour:
- Reset (async assert, sync release) clears all state and outputs:
  - state=IDLE.
  - in_ready, mem_wren, mem_rden, busy, done, error = 0.
  - mem_addr, mem_data, checksum = 0.
- State IDLE:
  - On start, latch base/count/verify_en, clear error, checksum and byte index.
  - If word_count==0: go to DONE. No RAM access.
  - If base_addr+word_count > IRAM_SIZE (17-bit compare, no wrap): set error, go to DONE. No RAM access.
  - Otherwise go to FILL.
- State FILL:
  - in_ready=1.
  - Each cycle with in_valid&in_ready, store the byte at lane byte_idx: byte 0 -> bits 7:0, byte 3 -> bits 31:24. byte_idx then increments.
  - Gaps in in_valid are allowed indefinitely.
  - On the 4th byte, go to WRITE.
- State WRITE (exactly 1 cycle):
  - in_ready=0, mem_wren=1, mem_addr=cur_addr, mem_data=assembled word.
  - checksum += word.
  - cur_addr++, remaining--.
  - If remaining becomes 0: go to VREAD if verify_en, else DONE. Otherwise go to FILL.
  - Minimum 5 cycles per word.
- mem_wren and mem_rden are never high together. mem_data holds its last value outside WRITE.
- State VREAD:
  - cur_addr=base.
  - mem_rden=1 for exactly word_count consecutive cycles, mem_addr incrementing each cycle.
  - A 1-cycle delayed valid accumulates mem_q into vsum.
  - Then go to VDRAIN.
- State VDRAIN (1 cycle): accumulate the final mem_q. Go to VCHK.
- State VCHK (1 cycle): error |= (vsum != checksum). Go to DONE.
- State DONE (1 cycle): done=1, busy=0. Go to IDLE.
- busy=1 in FILL, WRITE, VREAD, VDRAIN and VCHK.
- start asserted while busy: ignored; no latch, no error.
- Bytes presented while not in FILL are not consumed (in_ready=0).
- Reset mid-load: the load is abandoned. The RAM contents already written are left as-is and the partial word is discarded.
- Last legal write at address IRAM_SIZE-1 is allowed. cur_addr never exceeds it because of the range check.

Decomposition:
- Shared package/defines file holds:
  - IRAM_SIZE and ADDR_W constants, shared with the RAM wrapper.
  - State encodings: IDLE, FILL, WRITE, VREAD, VDRAIN, VCHK, DONE.
- One natural sub-module: iram_byte_packer. It holds the byte index, the 4-lane word register and a word_valid pulse, with valid/ready on its input.
- The FSM, address counter and checksum logic stay in iram_loader.

Test Plan:
- base=0x0010, count=2, verify_en=0; bytes 01 02 03 04 AA BB CC DD with no gaps -> writes 0x04030201@0x0010, then 0xDDCCBBAA@0x0011; checksum=0xE1CFBDAB; done pulse; error=0; busy low after done.
- Same data with verify_en=1, behavioural RAM model with 1-cycle read latency -> mem_rden high for 2 cycles at 0x0010 and 0x0011; no error; done 3 cycles after the last read issue.
- Verify run where the model corrupts word 0x0011 to 0xDDCCBBAB -> error=1 with done; error stays set until the next start.
- base=0x53FF, count=1 -> writes the last address. Then base=0x53FF, count=2 -> error=1, done next cycle, zero mem_wren cycles.
- count=0 -> done without any RAM access, error=0. A start pulse issued during FILL of another load -> ignored; the first load completes unchanged.
- Random in_valid gaps with reset_n dropped after 6 bytes of a 4-word load -> all outputs 0 immediately; exactly 1 write occurred; a new start then loads correctly from byte 0.
